inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter instruction_width, default 32, instruction and PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16, number of FETCH cycles without ack before fault.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-007 SHALL have port imem_addr  output  32  byte address of the requested instruction; equals pc.
REQ-008 SHALL have port imem_ack  input  1  memory accepts the request; imem_rdata is valid in the same cycle.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port instr  output  32  latched current instruction.
REQ-011 SHALL have port opcode  output  6  instr[31:26], driving the main controller.
REQ-012 SHALL have port instr_valid  output  1  instr and opcode are valid for decode/execute.
REQ-013 SHALL have port pc  output  32  address of the current instruction.
REQ-014 SHALL have port pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-015 SHALL have ports branch, jump, zero  input  1 each  from the main controller and ALU, sampled only in EXEC.
REQ-016 SHALL have port stall  input  1  holds EXEC; PC does not advance.
REQ-017 SHALL have port fetch_err  output  1  sticky fault: ack timeout.

Function
REQ-018 SHALL implement FSM states START, FETCH, EXEC, ERROR.
REQ-019 START SHALL go to FETCH unconditionally after one cycle.
REQ-020 FETCH SHALL assert imem_req; on imem_ack it SHALL latch imem_rdata into instr, clear the timeout counter and go to EXEC.
REQ-021 An ack in the first FETCH cycle SHALL be accepted; ack in any other state SHALL be ignored.
REQ-022 In FETCH without ack the timeout counter SHALL increment; when it reaches ACK_TIMEOUT the FSM SHALL go to ERROR.
REQ-023 EXEC SHALL assert instr_valid, deassert imem_req, and last exactly one cycle unless stall=1.
REQ-024 In EXEC with stall=0, pc SHALL load next_pc at the clock edge and the FSM SHALL go to FETCH; with stall=1, pc, instr and state SHALL hold.
REQ-025 next_pc SHALL be {pc_plus4[31:28], instr[25:0], 2'b00} if jump=1.
REQ-026 Otherwise, if branch=1 and zero=1, next_pc SHALL be pc_plus4 + (sign-extended instr[15:0] << 2), modulo 2^32.
REQ-027 Otherwise next_pc SHALL be pc_plus4.
REQ-028 Jump SHALL take priority over branch when both are 1.
REQ-029 PC arithmetic SHALL wrap: pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000.
REQ-030 ERROR SHALL deassert imem_req and instr_valid, assert fetch_err, and be left only by rst.

Reset
REQ-031 On rst: pc=RESET_PC, instr=0, opcode=0, instr_valid=0, imem_req=0, fetch_err=0, counter=0, state=START.
REQ-032 rst asserted mid-fetch or mid-EXEC SHALL abandon the transaction; a late ack after reset SHALL be ignored in START.
REQ-033 The first imem_req SHALL rise two cycles after rst falls (START, then FETCH).

Structure
REQ-034 A shared package SHALL hold FSM state encoding, RESET_PC, ACK_TIMEOUT, and opcode/immediate/jump-target field bounds.
REQ-035 Next-PC computation SHALL be one combinational sub-module, next_pc_calc.

Verification
REQ-036 Reset release, ack on first FETCH cycle with rdata=32'h8C08_0004 -> imem_addr=0, opcode=6'h23, instr_valid high for one cycle, next fetch at 32'h4.
REQ-037 pc=32'h100, instr imm=16'hFFFE, branch=1, zero=1 -> next imem_addr=32'hFC; with zero=0 -> 32'h104.
REQ-038 pc=32'h1000_0000, instr=32'h0800_0040, jump=1, branch=1, zero=1 -> next imem_addr=32'h1000_0100.
REQ-039 stall=1 for 3 EXEC cycles -> instr_valid stays high, pc is unchanged, imem_req stays low; advance on the cycle after stall drops.
REQ-040 No ack for 16 FETCH cycles -> fetch_err=1 and imem_req=0; a later ack is ignored; rst clears fetch_err and pc returns to RESET_PC.
REQ-041 rst pulsed while in FETCH with ack arriving the next cycle -> ack is ignored, instr stays 0, and a new fetch starts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, default
// parameters, and instruction field bounds.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
    localparam int          DEFAULT_ACK_TIMEOUT = 16;

    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;
    localparam int IMM_MSB     = 15;
    localparam int IMM_LSB     = 0;
    localparam int JTARGET_MSB = 25;
    localparam int JTARGET_LSB = 0;

    // Branch displacement in bytes: sign-extended word offset times four.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module next_pc_calc
    import inst_fetch_pkg::*;
#(
    parameter int instruction_width = 32
) (
    input  logic [instruction_width-1:0] pc,
    input  logic [25:0]                  jtarget,
    input  logic [15:0]                  imm,
    input  logic                         branch,
    input  logic                         jump,
    input  logic                         zero,
    output logic [instruction_width-1:0] pc_plus4,
    output logic [instruction_width-1:0] next_pc
);

    always_comb begin
        pc_plus4 = pc + instruction_width'(4);
        next_pc  = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[instruction_width-1:28], jtarget, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_offset(imm);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests a word from instruction memory, holds it
// for one execute cycle (or longer under stall) and then advances the PC.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                           instruction_width = 32,
    parameter logic [instruction_width-1:0] RESET_PC          = DEFAULT_RESET_PC,
    parameter int                           ACK_TIMEOUT       = DEFAULT_ACK_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [instruction_width-1:0] imem_addr,
    input  logic                         imem_ack,
    input  logic [instruction_width-1:0] imem_rdata,
    output logic [instruction_width-1:0] instr,
    output logic [5:0]                   opcode,
    output logic                         instr_valid,
    output logic [instruction_width-1:0] pc,
    output logic [instruction_width-1:0] pc_plus4,
    input  logic                         branch,
    input  logic                         jump,
    input  logic                         zero,
    input  logic                         stall,
    output logic                         fetch_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    fetch_state_t                 state_reg, state_next;
    logic [instruction_width-1:0] pc_reg, pc_next;
    logic [instruction_width-1:0] instr_reg, instr_next;
    logic [CNT_W-1:0]             cnt_reg, cnt_next;
    logic [CNT_W-1:0]             cnt_inc;
    logic [instruction_width-1:0] next_pc;

    next_pc_calc #(
        .instruction_width(instruction_width)
    ) u_next_pc_calc (
        .pc       (pc_reg),
        .jtarget  (instr_reg[JTARGET_MSB:JTARGET_LSB]),
        .imm      (instr_reg[IMM_MSB:IMM_LSB]),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_START;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_START: state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    cnt_next   = '0;
                    state_next = ST_EXEC;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
                        state_next = ST_ERROR;
                    end
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_next    = next_pc;
                    state_next = ST_FETCH;
                end
            end
            // Only reset leaves the fault state.
            default: state_next = ST_ERROR;
        endcase
    end

    assign imem_req    = (state_reg == ST_FETCH);
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == ST_EXEC);
    assign fetch_err   = (state_reg == ST_ERROR);
    assign instr       = instr_reg;
    assign opcode      = instr_reg[OPCODE_MSB:OPCODE_LSB];
    assign pc          = pc_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed-vector bench for inst_fetch, with a second instance at a high
// reset PC for jump-region tests and a bare next_pc_calc for wraparound.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst, rst_hi;
    logic        imem_ack, ack_hi;
    logic [31:0] imem_rdata;
    logic        branch, jump, zero, stall;

    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [5:0]  opcode;

    logic        req_hi, valid_hi, err_hi;
    logic [31:0] addr_hi, instr_hi, pc_hi, pc_plus4_hi;
    logic [5:0]  opcode_hi;

    logic [31:0] npc_pc, npc_plus4, npc_next;
    logic [25:0] npc_jt;
    logic [15:0] npc_imm;
    logic        npc_branch, npc_jump, npc_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .branch(branch), .jump(jump), .zero(zero), .stall(stall),
        .fetch_err(fetch_err)
    );

    inst_fetch #(.RESET_PC(32'h0FFF_FFFC)) u_dut_hi (
        .clk(clk), .rst(rst_hi), .imem_req(req_hi), .imem_addr(addr_hi),
        .imem_ack(ack_hi), .imem_rdata(imem_rdata), .instr(instr_hi),
        .opcode(opcode_hi), .instr_valid(valid_hi), .pc(pc_hi),
        .pc_plus4(pc_plus4_hi), .branch(branch), .jump(jump), .zero(zero),
        .stall(stall), .fetch_err(err_hi)
    );

    next_pc_calc u_npc (
        .pc(npc_pc), .jtarget(npc_jt), .imm(npc_imm), .branch(npc_branch),
        .jump(npc_jump), .zero(npc_zero), .pc_plus4(npc_plus4), .next_pc(npc_next)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word on the bus for a single cycle while the DUT is in FETCH.
    task automatic ack_main(input logic [31:0] word);
        imem_rdata = word;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic ack_hi_word(input logic [31:0] word);
        imem_rdata = word;
        ack_hi     = 1'b1;
        tick();
        ack_hi     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst_hi = 1'b1;
        imem_ack = 1'b0; ack_hi = 1'b0; imem_rdata = '0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0; stall = 1'b0;
        npc_pc = '0; npc_jt = '0; npc_imm = '0;
        npc_branch = 1'b0; npc_jump = 1'b0; npc_zero = 1'b0;
        tick();
        tick();

        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_err", 32'(fetch_err), 32'h0);

        // Jump priority in the 0x1000_0000 region.
        rst_hi = 1'b0;
        tick();
        check("hi_first_addr", addr_hi, 32'h0FFF_FFFC);
        check("hi_pc_plus4", pc_plus4_hi, 32'h1000_0000);
        ack_hi_word(32'h0800_0000);
        jump = 1'b1;
        tick();
        check("hi_jump_addr", addr_hi, 32'h1000_0000);
        ack_hi_word(32'h0800_0040);
        branch = 1'b1; zero = 1'b1;
        tick();
        jump = 1'b0; branch = 1'b0; zero = 1'b0;
        check("hi_jump_prio", addr_hi, 32'h1000_0100);
        rst_hi = 1'b1;

        // Wraparound at the top of the address space.
        npc_pc = 32'hFFFF_FFFC;
        #1;
        check("wrap_plus4", npc_plus4, 32'h0);
        check("wrap_next", npc_next, 32'h0);
        npc_imm = 16'h0001; npc_branch = 1'b1; npc_zero = 1'b1;
        #1;
        check("wrap_branch", npc_next, 32'h0000_0004);

        // Reset release and first fetch.
        rst = 1'b0;
        check("start_req", 32'(imem_req), 32'h0);
        tick();
        check("fetch_req", 32'(imem_req), 32'h1);
        check("fetch_addr0", imem_addr, 32'h0);
        ack_main(32'h8C08_0004);
        check("exec_valid", 32'(instr_valid), 32'h1);
        check("exec_opcode", 32'(opcode), 32'h23);
        check("exec_instr", instr, 32'h8C08_0004);
        check("exec_req", 32'(imem_req), 32'h0);
        tick();
        check("valid_one_cycle", 32'(instr_valid), 32'h0);
        check("seq_addr", imem_addr, 32'h4);

        // Jump to 0x100, then branch back with imm=-2 (taken / not taken).
        ack_main(32'h0800_0040);
        jump = 1'b1; tick(); jump = 1'b0;
        check("jump_addr", imem_addr, 32'h100);
        ack_main(32'h1000_FFFE);
        branch = 1'b1; zero = 1'b1; tick(); branch = 1'b0; zero = 1'b0;
        check("branch_taken", imem_addr, 32'hFC);
        ack_main(32'h0800_0040);
        jump = 1'b1; tick(); jump = 1'b0;
        check("jump_back", imem_addr, 32'h100);
        ack_main(32'h1000_FFFE);
        branch = 1'b1; zero = 1'b0; tick(); branch = 1'b0;
        check("branch_not_taken", imem_addr, 32'h104);

        // Stall holds EXEC for three cycles.
        ack_main(32'h0000_0020);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_valid_%0d", i), 32'(instr_valid), 32'h1);
            check($sformatf("stall_pc_%0d", i), pc, 32'h104);
            check($sformatf("stall_req_%0d", i), 32'(imem_req), 32'h0);
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        check("post_stall_addr", imem_addr, 32'h108);
        check("post_stall_valid", 32'(instr_valid), 32'h0);

        // Ack timeout after 16 FETCH cycles.
        for (int i = 0; i < 15; i++) tick();
        check("pre_timeout_req", 32'(imem_req), 32'h1);
        check("pre_timeout_err", 32'(fetch_err), 32'h0);
        tick();
        check("timeout_err", 32'(fetch_err), 32'h1);
        check("timeout_req", 32'(imem_req), 32'h0);
        ack_main(32'hFFFF_FFFF);
        check("late_ack_err", 32'(fetch_err), 32'h1);
        check("late_ack_instr", instr, 32'h0000_0020);
        check("late_ack_valid", 32'(instr_valid), 32'h0);
        rst = 1'b1;
        tick();
        check("err_cleared", 32'(fetch_err), 32'h0);
        check("err_rst_pc", pc, 32'h0);
        check("err_rst_instr", instr, 32'h0);

        // Reset mid-fetch; ack in START is ignored.
        rst = 1'b0;
        tick();
        check("refetch_req", 32'(imem_req), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ack_main(32'hDEAD_BEEF);
        check("abort_instr", instr, 32'h0);
        check("abort_req", 32'(imem_req), 32'h1);
        check("abort_addr", imem_addr, 32'h0);
        check("abort_valid", 32'(instr_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
